// File: rtl/mac_pkg.sv
// mac_pkg: shared instruction encodings and sequencer states for mac_array control
package mac_pkg;
  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;
  typedef enum logic [2:0] {IDLE, LOAD_K, GAP, EXEC, DRAIN, DONE} state_t;
endpackage

// File: rtl/mac_array_ctrl_if.sv
// mac_array_ctrl_if: control, SRAM read-port and mac_array signals of the sequencer
interface mac_array_ctrl_if #(
  parameter int col    = 8,
  parameter int ADDR_W = 4,
  parameter int QCNT_W = 4
);
  logic              start;
  logic [QCNT_W-1:0] num_q;
  logic              busy;
  logic              done;
  logic              kmem_cen;
  logic [ADDR_W-1:0] kmem_addr;
  logic              qmem_cen;
  logic [ADDR_W-1:0] qmem_addr;
  logic [1:0]        inst;
  logic [col-1:0]    fifo_wr;
  logic              ofifo_full;
  modport master (
    output start, num_q, fifo_wr, ofifo_full,
    input  busy, done, kmem_cen, kmem_addr, qmem_cen, qmem_addr, inst
  );
  modport slave (
    input  start, num_q, fifo_wr, ofifo_full,
    output busy, done, kmem_cen, kmem_addr, qmem_cen, qmem_addr, inst
  );
endinterface

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: loads kernel rows, streams queries under FIFO backpressure, counts results
module mac_array_ctrl
  import mac_pkg::*;
#(
  parameter int col    = 8,
  parameter int ADDR_W = 4,
  parameter int QCNT_W = 4
) (
  input logic clk,
  input logic reset,
  mac_array_ctrl_if.slave bus
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [QCNT_W-1:0] nq_q, nq_d, iss_q, iss_d, res_q, res_d;
  logic [1:0]        inst_q, inst_d;
  logic              k_go, q_go, row;
  always_comb begin
    k_go    = state_q == LOAD_K;
    q_go    = state_q == EXEC && !bus.ofifo_full;
    row     = bus.fifo_wr[col-1] && (state_q == EXEC || state_q == DRAIN) && res_q != nq_q;
    nq_d    = state_q == IDLE && bus.start ? bus.num_q : nq_q;
    k_d     = k_go && k_q != ADDR_W'(col - 1) ? k_q + 1'b1 : '0;
    iss_d   = q_go ? iss_q + 1'b1 : state_q == DONE ? '0 : iss_q;
    res_d   = row ? res_q + 1'b1 : state_q == DONE ? '0 : res_q;
    // inst lags the SRAM enable by the one-cycle read latency
    inst_d  = k_go ? INST_LOAD : q_go ? INST_EXEC : INST_IDLE;
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = LOAD_K;
      LOAD_K:  if (k_q == ADDR_W'(col - 1)) state_d = GAP;
      GAP:     state_d = nq_q == '0 ? DONE : EXEC;
      EXEC:    if (iss_d == nq_q) state_d = DRAIN;
      DRAIN:   if (res_d == nq_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      nq_q    <= '0;
      iss_q   <= '0;
      res_q   <= '0;
      inst_q  <= INST_IDLE;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      nq_q    <= nq_d;
      iss_q   <= iss_d;
      res_q   <= res_d;
      inst_q  <= inst_d;
    end
  end
  assign bus.kmem_cen  = !k_go;
  assign bus.kmem_addr = k_q;
  assign bus.qmem_cen  = !q_go;
  assign bus.qmem_addr = ADDR_W'(iss_q);
  assign bus.inst      = inst_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = state_q == DONE;
endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb_mac_array_ctrl: directed checks of the sequencer against a delay model of mac_array
module tb_mac_array_ctrl;
  import mac_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic extra = 1'b0;
  logic [2:0] pipe = '0;
  int total = 0, bad = 0;
  int k_n = 0, l_n = 0, e_n = 0, q_n = 0, d_n = 0, err_n = 0, cyc = 0;
  int fw_cyc = 0, done_cyc = 0, kidx = 0;
  int k0, l0, e0, q0, d0, err0;
  logic prev_kcen = 1'b1, prev_qcen = 1'b1, prev_done = 1'b0, r_pos = 1'b1;
  logic [3:0] qa[$];
  always #5 clk = ~clk;
  mac_array_ctrl_if #(.col(8), .ADDR_W(4), .QCNT_W(4)) bus();
  mac_array_ctrl #(.col(8), .ADDR_W(4), .QCNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always @(posedge clk) begin
    pipe <= {pipe[1:0], bus.inst == INST_EXEC};
    r_pos <= reset;
  end
  assign bus.fifo_wr = {pipe[2] | extra, 7'd0};
  always @(negedge clk) begin
    cyc++;
    if (!bus.kmem_cen) begin
      if (int'(bus.kmem_addr) != kidx) err_n++;
      kidx++;
      k_n++;
    end else kidx = 0;
    if (!bus.qmem_cen) begin
      qa.push_back(bus.qmem_addr);
      q_n++;
    end
    if (bus.inst == INST_LOAD) l_n++;
    if (bus.inst == INST_EXEC) e_n++;
    if (!r_pos && ((bus.inst == INST_LOAD) != !prev_kcen)) err_n++;
    if (!r_pos && ((bus.inst == INST_EXEC) != !prev_qcen)) err_n++;
    if (prev_done && bus.busy) err_n++;
    if (bus.done && !bus.busy) err_n++;
    if (bus.done) begin
      d_n++;
      done_cyc = cyc;
    end
    if (bus.fifo_wr[7]) fw_cyc = cyc;
    prev_kcen = bus.kmem_cen;
    prev_qcen = bus.qmem_cen;
    prev_done = bus.done;
  end
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic snap();
    k0 = k_n; l0 = l_n; e0 = e_n; q0 = q_n; d0 = d_n; err0 = err_n;
  endtask
  task automatic go(input int nq);
    snap();
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.num_q = 4'(nq);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(bus.busy), 0);
    repeat (2) @(negedge clk);
  endtask
  task automatic wait_exec(input string tag);
    int n = 0;
    while (bus.inst != INST_EXEC && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(bus.inst), int'(INST_EXEC));
  endtask
  task automatic chk_qa(input string tag, input int n);
    for (int i = 0; i < n; i++) chk(tag, int'(qa[q0 + i]), i);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.num_q = '0;
    bus.ofifo_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_kcen", int'(bus.kmem_cen), 1);
    chk("rst_qcen", int'(bus.qmem_cen), 1);
    chk("rst_kaddr", int'(bus.kmem_addr), 0);
    chk("rst_qaddr", int'(bus.qmem_addr), 0);
    chk("rst_inst", int'(bus.inst), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    #1 reset = 1'b0;
    go(3);
    chk("t1_busy", int'(bus.busy), 1);
    wait_idle("t1_idle");
    chk("t1_kcen", k_n - k0, 8);
    chk("t1_load", l_n - l0, 8);
    chk("t1_exec", e_n - e0, 3);
    chk("t1_iss", q_n - q0, 3);
    chk_qa("t1_qaddr", 3);
    chk("t1_done", d_n - d0, 1);
    chk("t1_lat", done_cyc - fw_cyc, 1);
    chk("t1_err", err_n - err0, 0);
    go(4);
    begin
      int n = 0;
      while (!(!bus.qmem_cen && bus.qmem_addr == 4'd1) && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("t2_iss1", int'(bus.qmem_addr), 1);
    end
    @(posedge clk); #1 bus.ofifo_full = 1'b1;
    @(negedge clk);
    chk("t2_st1_cen", int'(bus.qmem_cen), 1);
    chk("t2_st1_addr", int'(bus.qmem_addr), 2);
    @(negedge clk);
    chk("t2_st2_cen", int'(bus.qmem_cen), 1);
    chk("t2_st2_addr", int'(bus.qmem_addr), 2);
    @(posedge clk); #1 bus.ofifo_full = 1'b0;
    wait_idle("t2_idle");
    chk("t2_exec", e_n - e0, 4);
    chk("t2_iss", q_n - q0, 4);
    chk_qa("t2_qaddr", 4);
    chk("t2_done", d_n - d0, 1);
    go(0);
    wait_idle("t3_idle");
    chk("t3_kcen", k_n - k0, 8);
    chk("t3_load", l_n - l0, 8);
    chk("t3_exec", e_n - e0, 0);
    chk("t3_iss", q_n - q0, 0);
    chk("t3_done", d_n - d0, 1);
    go(3);
    wait_exec("t4_exec_seen");
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.num_q = 4'd9;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_idle("t4_idle");
    repeat (10) @(negedge clk);
    chk("t4_busy", int'(bus.busy), 0);
    chk("t4_exec", e_n - e0, 3);
    chk("t4_iss", q_n - q0, 3);
    chk("t4_done", d_n - d0, 1);
    go(3);
    begin
      int n = 0;
      while (!(!bus.kmem_cen && bus.kmem_addr == 4'd4) && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("t5_kaddr4", int'(bus.kmem_addr), 4);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("t5_kcen", int'(bus.kmem_cen), 1);
    chk("t5_qcen", int'(bus.qmem_cen), 1);
    chk("t5_kaddr", int'(bus.kmem_addr), 0);
    chk("t5_qaddr", int'(bus.qmem_addr), 0);
    chk("t5_inst", int'(bus.inst), 0);
    chk("t5_busy", int'(bus.busy), 0);
    chk("t5_state", int'(dut.state_q), int'(IDLE));
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_nodone", d_n - d0, 0);
    go(2);
    wait_idle("t5_idle");
    chk("t5_exec", e_n - e0, 2);
    chk("t5_done", d_n - d0, 1);
    go(2);
    wait_exec("t6_exec_seen");
    #1 extra = 1'b1;
    repeat (5) @(negedge clk);
    extra = 1'b0;
    wait_idle("t6_idle");
    extra = 1'b1;
    repeat (3) @(negedge clk);
    extra = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_exec", e_n - e0, 2);
    chk("t6_done", d_n - d0, 1);
    chk("t6_busy", int'(bus.busy), 0);
    chk("all_err", err_n, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
